// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pkg
// Brief  : Shared constants, register map and FSM encoding for the
//          rectangle-fill engine.
// Rev    : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int H_MAX_DEF = 159;
    localparam int V_MAX_DEF = 119;

    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_X1     = 3'd2;
    localparam logic [2:0] REG_Y1     = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [7:0] REG_COUNT  = 8'd6;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_PIXEL_BIT = 1;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_rect_fill_if.sv
`default_nettype none
// ============================================================================
// Module : vga_rect_fill_if
// Brief  : Processor address/strobe and frame-buffer write port of the
//          rectangle-fill engine. The tristate data bus stays a plain port.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_rect_fill_if;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic        FB_WE;
    logic        BUSY;
    logic        DONE_IRQ;

    modport master (
        output BUS_ADDR, BUS_WE,
        input  FB_ADDR, FB_DATA, FB_WE, BUSY, DONE_IRQ
    );

    modport slave (
        input  BUS_ADDR, BUS_WE,
        output FB_ADDR, FB_DATA, FB_WE, BUSY, DONE_IRQ
    );
endinterface
`default_nettype wire

// File: rtl/vga_fill_regs.sv
`default_nettype none
// ============================================================================
// Module : vga_fill_regs
// Brief  : Bus decode, register bank and tristate read-back for the fill engine.
// Rev    : 1.0  initial release
// ============================================================================
module vga_fill_regs
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB4
) (
    input  wire        CLK,
    input  wire        RESET,
    inout  wire  [7:0] BUS_DATA,
    input  wire  [7:0] bus_addr_i,
    input  wire        bus_we_i,
    input  wire        busy_i,
    input  wire        done_set_i,
    input  wire        done_clr_i,
    output logic [7:0] x0_o,
    output logic [7:0] y0_o,
    output logic [7:0] x1_o,
    output logic [7:0] y1_o,
    output logic       pixel_o,
    output logic       start_o
);

    logic [7:0] offset_d;
    logic       hit_d;
    logic       wr_d;
    logic [7:0] rd_mux_d;

    logic [7:0] x0_q, y0_q, x1_q, y1_q;
    logic       pixel_q;
    logic       done_q;
    logic       oe_q;
    logic [7:0] rdata_q;

    assign offset_d = bus_addr_i - BASE_ADDR;
    assign hit_d    = (offset_d < REG_COUNT);
    assign wr_d     = hit_d && bus_we_i;
    // START is a strobe only; it is never stored, so CTRL reads it back as 0.
    assign start_o  = wr_d && (offset_d[2:0] == REG_CTRL) && BUS_DATA[CTRL_START_BIT];

    always_comb begin
        rd_mux_d = 8'h00;
        case (offset_d[2:0])
            REG_X0:     rd_mux_d = x0_q;
            REG_Y0:     rd_mux_d = y0_q;
            REG_X1:     rd_mux_d = x1_q;
            REG_Y1:     rd_mux_d = y1_q;
            REG_CTRL:   rd_mux_d[CTRL_PIXEL_BIT] = pixel_q;
            REG_STATUS: begin
                rd_mux_d[STAT_BUSY_BIT] = busy_i;
                rd_mux_d[STAT_DONE_BIT] = done_q;
            end
            default:    rd_mux_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0_q    <= 8'h00;
            y0_q    <= 8'h00;
            x1_q    <= 8'h00;
            y1_q    <= 8'h00;
            pixel_q <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            if (wr_d) begin
                case (offset_d[2:0])
                    REG_X0:   x0_q    <= BUS_DATA;
                    REG_Y0:   y0_q    <= BUS_DATA;
                    REG_X1:   x1_q    <= BUS_DATA;
                    REG_Y1:   y1_q    <= BUS_DATA;
                    REG_CTRL: pixel_q <= BUS_DATA[CTRL_PIXEL_BIT];
                    default:  ;
                endcase
            end
            if (done_clr_i) begin
                done_q <= 1'b0;
            end else if (done_set_i) begin
                done_q <= 1'b1;
            end
            oe_q    <= hit_d && !bus_we_i;
            rdata_q <= rd_mux_d;
        end
    end

    assign BUS_DATA = oe_q ? rdata_q : 8'hzz;

    assign x0_o    = x0_q;
    assign y0_o    = y0_q;
    assign x1_o    = x1_q;
    assign y1_o    = y1_q;
    assign pixel_o = pixel_q;

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module : vga_rect_fill
// Brief  : Rectangle-fill engine writing one pixel per cycle into a frame
//          buffer. Define RECT_FILL_CLIP_EN to clamp coordinates to the screen.
// Rev    : 1.0  initial release
// ============================================================================
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB4,
    parameter int         H_MAX     = H_MAX_DEF,
    parameter int         V_MAX     = V_MAX_DEF
) (
    input  wire              CLK,
    input  wire              RESET,
    inout  wire  [7:0]       BUS_DATA,
    vga_rect_fill_if.slave   vif
);

`ifdef RECT_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [7:0] H_LIM = 8'(H_MAX);
    localparam logic [7:0] V_LIM = 8'(V_MAX);

    logic [7:0] x0_d, y0_d, x1_d, y1_d;
    logic       pixel_d, start_d, done_clr_d;
    logic [7:0] xa_d, xb_d, ya_d, yb_d;
    logic [7:0] xs_d, xe_d, ys_d, ye_d;
    logic [7:0] x_inc_d, y_inc_d;

    fill_state_t state_q;
    logic [7:0]  x_q, y_q, xs_q, xe_q, ye_q;
    logic [14:0] fb_addr_q;
    logic        fb_data_q, fb_we_q, busy_q, irq_q;

    vga_fill_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUS_DATA   (BUS_DATA),
        .bus_addr_i (vif.BUS_ADDR),
        .bus_we_i   (vif.BUS_WE),
        .busy_i     (busy_q),
        .done_set_i (irq_q),
        .done_clr_i (done_clr_d),
        .x0_o       (x0_d),
        .y0_o       (y0_d),
        .x1_o       (x1_d),
        .y1_o       (y1_d),
        .pixel_o    (pixel_d),
        .start_o    (start_d)
    );

    assign done_clr_d = start_d && (state_q == ST_IDLE);

    assign xa_d = CLIP_EN ? clamp8(x0_d, H_LIM) : x0_d;
    assign xb_d = CLIP_EN ? clamp8(x1_d, H_LIM) : x1_d;
    assign ya_d = CLIP_EN ? clamp8(y0_d, V_LIM) : y0_d;
    assign yb_d = CLIP_EN ? clamp8(y1_d, V_LIM) : y1_d;

    assign xs_d = (xa_d < xb_d) ? xa_d : xb_d;
    assign xe_d = (xa_d < xb_d) ? xb_d : xa_d;
    assign ys_d = (ya_d < yb_d) ? ya_d : yb_d;
    assign ye_d = (ya_d < yb_d) ? yb_d : ya_d;

    assign x_inc_d = x_q + 8'd1;
    assign y_inc_d = y_q + 8'd1;

    // Outputs are registered alongside the counters, so FB_ADDR always
    // carries the pixel the counters currently point at.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            x_q       <= 8'h00;
            y_q       <= 8'h00;
            xs_q      <= 8'h00;
            xe_q      <= 8'h00;
            ye_q      <= 8'h00;
            fb_addr_q <= 15'h0000;
            fb_data_q <= 1'b0;
            fb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    xs_q      <= xs_d;
                    xe_q      <= xe_d;
                    ye_q      <= ye_d;
                    x_q       <= xs_d;
                    y_q       <= ys_d;
                    fb_addr_q <= {ys_d[6:0], xs_d};
                    fb_data_q <= pixel_d;
                    fb_we_q   <= 1'b1;
                    state_q   <= ST_FILL;
                end
                ST_FILL: begin
                    if (x_q < xe_q) begin
                        x_q       <= x_inc_d;
                        fb_addr_q <= {y_q[6:0], x_inc_d};
                    end else if (y_q < ye_q) begin
                        x_q       <= xs_q;
                        y_q       <= y_inc_d;
                        fb_addr_q <= {y_inc_d[6:0], xs_q};
                    end else begin
                        fb_we_q <= 1'b0;
                        busy_q  <= 1'b0;
                        irq_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vif.FB_ADDR  = fb_addr_q;
    assign vif.FB_DATA  = fb_data_q;
    assign vif.FB_WE    = fb_we_q;
    assign vif.BUSY     = busy_q;
    assign vif.DONE_IRQ = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_rect_fill
// Brief  : Self-checking bench for vga_rect_fill against a cycle-scheduled
//          rectangle model plus hand-computed literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_rect_fill;

    localparam logic [7:0] BASE      = 8'hB4;
    localparam logic [7:0] IDLE_ADDR = 8'h00;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic        d;
    } wr_t;

    logic       CLK;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] tb_dout;
    logic       tb_drv;

    vga_rect_fill_if vif ();

    assign BUS_DATA = tb_drv ? tb_dout : 8'hzz;

    vga_rect_fill dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (BUS_DATA),
        .vif      (vif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= RESET;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model state: register shadows and the scheduled write list of the fill.
    logic [7:0]  sh_x0, sh_y0, sh_x1, sh_y1;
    logic        sh_pix;
    wr_t         q[$];
    bit          m_valid = 1'b0;
    int          m_k, m_n;
    logic [14:0] got_a[$];
    logic        got_d[$];
    int          irq_cnt = 0;
    bit          chk_en  = 1'b0;

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a < b) ? b : a; endfunction

    task automatic model_start(input int k);
        int xa, xb, ya, yb, xs, xe, ys, ye, n;
        xa = sh_x0; xb = sh_x1; ya = sh_y0; yb = sh_y1;
`ifdef RECT_FILL_CLIP_EN
        xa = imin(xa, 159); xb = imin(xb, 159);
        ya = imin(ya, 119); yb = imin(yb, 119);
`endif
        xs = imin(xa, xb); xe = imax(xa, xb);
        ys = imin(ya, yb); ye = imax(ya, yb);
        n = 0;
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) begin
                q.push_back('{k + 1 + n, 15'(((y & 127) * 256) + x), sh_pix});
                n++;
            end
        end
        m_k = k; m_n = n; m_valid = 1'b1;
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
        vif.BUS_ADDR = BASE + {5'd0, off};
        vif.BUS_WE   = 1'b1;
        tb_dout      = d;
        tb_drv       = 1'b1;
        @(posedge CLK); #1;
        vif.BUS_WE   = 1'b0;
        tb_drv       = 1'b0;
        vif.BUS_ADDR = IDLE_ADDR;
        case (off)
            3'd0: sh_x0 = d;
            3'd1: sh_y0 = d;
            3'd2: sh_x1 = d;
            3'd3: sh_y1 = d;
            3'd4: begin
                sh_pix = d[1];
                if (d[0] && (!m_valid || cyc >= m_k + m_n + 3)) model_start(cyc);
            end
            default: ;
        endcase
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [7:0] d);
        vif.BUS_ADDR = BASE + {5'd0, off};
        vif.BUS_WE   = 1'b0;
        @(posedge CLK); #1;
        vif.BUS_ADDR = IDLE_ADDR;
        d = BUS_DATA;
        @(posedge CLK); #1;
    endtask

    task automatic rect(input logic [7:0] x0, y0, x1, y1, input logic pix);
        bus_wr(3'd0, x0);
        bus_wr(3'd1, y0);
        bus_wr(3'd2, x1);
        bus_wr(3'd3, y1);
        got_a.delete(); got_d.delete(); irq_cnt = 0;
        bus_wr(3'd4, {6'd0, pix, 1'b1});
    endtask

    task automatic settle();
        repeat (m_n + 6) @(posedge CLK);
        #1;
    endtask

    // Per-cycle comparison of every output against the model schedule.
    always @(negedge CLK) begin
        if (chk_en) begin
            if (rst_seen) begin
                q.delete();
                m_valid = 1'b0;
                chk("rst_fb_we",   {31'd0, vif.FB_WE},    32'd0);
                chk("rst_fb_addr", {17'd0, vif.FB_ADDR},  32'd0);
                chk("rst_fb_data", {31'd0, vif.FB_DATA},  32'd0);
                chk("rst_busy",    {31'd0, vif.BUSY},     32'd0);
                chk("rst_irq",     {31'd0, vif.DONE_IRQ}, 32'd0);
            end else begin
                bit exp_we;
                exp_we = (q.size() > 0) && (q[0].cyc == cyc);
                chk("fb_we", {31'd0, vif.FB_WE}, {31'd0, exp_we});
                if (exp_we) begin
                    chk("fb_addr", {17'd0, vif.FB_ADDR}, {17'd0, q[0].addr});
                    chk("fb_data", {31'd0, vif.FB_DATA}, {31'd0, q[0].d});
                    void'(q.pop_front());
                end
                chk("busy", {31'd0, vif.BUSY},
                    {31'd0, m_valid && cyc >= m_k && cyc <= m_k + m_n});
                chk("done_irq", {31'd0, vif.DONE_IRQ},
                    {31'd0, m_valid && cyc == m_k + m_n + 1});
            end
            if (vif.FB_WE === 1'b1) begin
                got_a.push_back(vif.FB_ADDR);
                got_d.push_back(vif.FB_DATA);
            end
            if (vif.DONE_IRQ === 1'b1) irq_cnt++;
        end
    end

    initial begin
        logic [7:0]  rd;
        logic [14:0] e34[6];
        e34 = '{15'h050A, 15'h050B, 15'h050C, 15'h060A, 15'h060B, 15'h060C};
        RESET = 1'b1; tb_drv = 1'b0; tb_dout = 8'h00;
        vif.BUS_ADDR = IDLE_ADDR; vif.BUS_WE = 1'b0;
        sh_x0 = 0; sh_y0 = 0; sh_x1 = 0; sh_y1 = 0; sh_pix = 0;
        @(posedge CLK); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK); #1;
        bus_rd(3'd5, rd); chk("reset_status", {24'd0, rd}, 32'h00);
        bus_rd(3'd0, rd); chk("reset_x0",     {24'd0, rd}, 32'h00);

        // 3x2 rectangle, pixel 1
        rect(8'd10, 8'd5, 8'd12, 8'd6, 1'b1);
        settle();
        chk("r34_count", got_a.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_a.size()) chk("r34_addr", {17'd0, got_a[i]}, {17'd0, e34[i]});
        end
        chk("r34_irq_count", irq_cnt, 1);
        bus_rd(3'd4, rd); chk("ctrl_start_selfclear", {24'd0, rd}, 32'h02);
        bus_rd(3'd5, rd); chk("status_done", {24'd0, rd}, 32'h02);

        // swapped X corners on a single row
        rect(8'd12, 8'd3, 8'd10, 8'd3, 1'b1);
        settle();
        chk("r35_count", got_a.size(), 3);
        if (got_a.size() == 3) begin
            chk("r35_first", {17'd0, got_a[0]}, 32'h030A);
            chk("r35_last",  {17'd0, got_a[2]}, 32'h030C);
        end

        // degenerate single pixel at origin, pixel 0
        rect(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        settle();
        chk("r36_count", got_a.size(), 1);
        if (got_a.size() == 1) begin
            chk("r36_addr", {17'd0, got_a[0]}, 32'h0);
            chk("r36_data", {31'd0, got_d[0]}, 32'h0);
        end
        bus_rd(3'd5, rd); chk("r36_status", {24'd0, rd}, 32'h02);

        // second START mid-fill must be ignored; register still updates
        rect(8'd0, 8'd0, 8'd3, 8'd3, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        bus_wr(3'd0, 8'd50);
        bus_wr(3'd4, 8'h03);
        settle();
        chk("r37_count", got_a.size(), 16);
        chk("r37_irq_count", irq_cnt, 1);
        bus_rd(3'd0, rd); chk("r37_x0_updated", {24'd0, rd}, 32'd50);

        // reset after three writes of a 4x4 fill
        rect(8'd20, 8'd30, 8'd23, 8'd33, 1'b1);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        sh_x0 = 0; sh_y0 = 0; sh_x1 = 0; sh_y1 = 0; sh_pix = 0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("r38_count", got_a.size(), 3);
        chk("r38_irq_count", irq_cnt, 0);
        chk("r38_busy", {31'd0, vif.BUSY}, 32'd0);
        bus_rd(3'd0, rd); chk("r38_x0",     {24'd0, rd}, 32'd0);
        bus_rd(3'd3, rd); chk("r38_y1",     {24'd0, rd}, 32'd0);
        bus_rd(3'd4, rd); chk("r38_ctrl",   {24'd0, rd}, 32'd0);
        bus_rd(3'd5, rd); chk("r38_status", {24'd0, rd}, 32'd0);

        // corner rectangle beyond the screen edge
        rect(8'd158, 8'd118, 8'd200, 8'd127, 1'b1);
        settle();
`ifdef RECT_FILL_CLIP_EN
        chk("r39_count", got_a.size(), 4);
        if (got_a.size() == 4) chk("r39_last", {17'd0, got_a[3]}, 32'h779F);
`else
        chk("r39_count", got_a.size(), 430);
        if (got_a.size() == 430) chk("r39_last", {17'd0, got_a[429]}, 32'h7FC8);
`endif
        chk("r39_irq_count", irq_cnt, 1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hB4, giving the bus address of register offset 0.
REQ-002 SHALL have parameter H_MAX, default 159, giving the last visible X coordinate.
REQ-003 SHALL have parameter V_MAX, default 119, giving the last visible Y coordinate.
REQ-004 SHALL have port CLK, input, 1 bit, system clock; all logic is on the rising edge.
REQ-005 SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port BUS_DATA, inout, 8 bits, shared processor data bus.
REQ-007 SHALL have port BUS_ADDR, input, 8 bits, processor address.
REQ-008 SHALL have port BUS_WE, input, 1 bit, processor write strobe.
REQ-009 SHALL have port FB_ADDR, output, 15 bits, frame-buffer write address {Y[6:0],X[7:0]}.
REQ-010 SHALL have port FB_DATA, output, 1 bit, pixel value to write.
REQ-011 SHALL have port FB_WE, output, 1 bit, frame-buffer write enable.
REQ-012 SHALL have port BUSY, output, 1 bit, high while a fill is in progress.
REQ-013 SHALL have port DONE_IRQ, output, 1 bit, one-cycle pulse when a fill completes.

Function
REQ-014 SHALL map the registers at BASE_ADDR+0..5 as: X0, Y0, X1, Y1, CTRL (bit0 START, bit1 PIXEL), STATUS (bit0 BUSY, bit1 DONE; read-only).
REQ-015 SHALL write a register when BUS_WE=1 and BUS_ADDR is in range; writes to STATUS are ignored.
REQ-016 SHALL drive the addressed register onto BUS_DATA the cycle after a read (BUS_WE=0) in range; otherwise BUS_DATA is high-Z.
REQ-017 SHALL self-clear CTRL.START; it reads back 0.
REQ-018 SHALL implement FSM IDLE -> SETUP -> FILL -> DONE -> IDLE.
REQ-019 IDLE: a write with CTRL.START=1 moves the FSM to SETUP and clears STATUS.DONE; a START written while not in IDLE is ignored.
REQ-020 SETUP (1 cycle): SHALL latch xs=min(X0,X1), xe=max(X0,X1), ys=min(Y0,Y1), ye=max(Y0,Y1) and PIXEL, and set x=xs, y=ys.
REQ-021 FILL: each cycle SHALL assert FB_WE=1 with FB_ADDR={y[6:0],x} and FB_DATA=latched PIXEL.
REQ-022 FILL: if x<xe, x increments; else x resets to xs and y increments; at x=xe and y=ye, the FSM moves to DONE.
REQ-023 SHALL give the first FB_WE two cycles after the START write cycle, then exactly (xe-xs+1)*(ye-ys+1) consecutive write cycles.
REQ-024 DONE (1 cycle): DONE_IRQ=1 and STATUS.DONE set (sticky); FB_WE=0.
REQ-025 BUSY SHALL be 1 in SETUP and FILL only.
REQ-026 Coordinate or CTRL writes during SETUP, FILL or DONE SHALL update the registers but not the fill in progress.
REQ-027 A degenerate rectangle (X0=X1, Y0=Y1) SHALL produce exactly one write.

Reset
REQ-028 RESET SHALL set FSM=IDLE, all registers=0, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, DONE_IRQ=0, and BUS_DATA to high-Z.
REQ-029 RESET during FILL SHALL abort the fill; FB_WE=0 from the next cycle, and no DONE_IRQ is generated.

Configuration
REQ-030 With RECT_FILL_CLIP_EN defined, SETUP SHALL clamp X values >H_MAX to H_MAX and Y values >V_MAX to V_MAX before min/max.
REQ-031 Without RECT_FILL_CLIP_EN, coordinates SHALL be used unclamped; only Y[6:0] enters FB_ADDR, and the fill wraps in address space.

Structure
REQ-032 Package vga_pkg SHALL hold H_MAX/V_MAX defaults, register offsets, CTRL/STATUS bit positions and the FSM state encoding.
REQ-033 The bus decode, register bank and tristate SHALL be in sub-module vga_fill_regs; vga_rect_fill holds the FSM and counters.

Verification
REQ-034 X0=10,Y0=5,X1=12,Y1=6,PIXEL=1,START -> 6 writes in order to addresses {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}, then one DONE_IRQ pulse.
REQ-035 X0=12,X1=10 (swapped), Y0=Y1=3 -> writes to x=10,11,12 on y=3 only.
REQ-036 X0=X1=0,Y0=Y1=0,PIXEL=0 -> a single write to address 0 with FB_DATA=0; STATUS reads 8'h02.
REQ-037 Second START written mid-fill -> ignored; the write count equals the first rectangle's area and there is one DONE_IRQ.
REQ-038 RESET asserted after 3 writes of a 4x4 fill -> FB_WE=0 next cycle, BUSY=0, no DONE_IRQ, registers read 0.
REQ-039 RECT_FILL_CLIP_EN defined with X1=200,Y1=127 from (158,118) -> writes cover x=158..159, y=118..119 (4 writes).
